// File: rtl/fcvtint_pipe_if.sv
// Handshake and data bundle for the float->integer result finaliser.
// The Mod signal exists only when FCVTMOD_EN is defined.
interface fcvtint_pipe_if #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NORMSHIFTSZ = 128
);
  logic                   InValid;
  logic                   InReady;
  logic                   Signed;
  logic                   Int64;
  logic                   Plus1;
  logic                   Xs;
  logic                   NaN;
  logic                   ShiftOvf;
  logic [NORMSHIFTSZ-1:0] Shifted;
`ifdef FCVTMOD_EN
  logic                   Mod;
`endif
  logic                   OutValid;
  logic                   OutReady;
  logic [XLEN-1:0]        CvtRes;
  logic                   CvtNV;

  // Upstream shifter / downstream consumer side
  modport master (
`ifdef FCVTMOD_EN
    output Mod,
`endif
    output InValid, Signed, Int64, Plus1, Xs, NaN, ShiftOvf, Shifted, OutReady,
    input  InReady, OutValid, CvtRes, CvtNV
  );

  // Finaliser side
  modport slave (
`ifdef FCVTMOD_EN
    input  Mod,
`endif
    input  InValid, Signed, Int64, Plus1, Xs, NaN, ShiftOvf, Shifted, OutReady,
    output InReady, OutValid, CvtRes, CvtNV
  );
endinterface

// File: rtl/fcvtint_pipe.sv
// Two-stage float->integer result finaliser: S1 registers the rounded magnitude,
// S2 registers the signed/saturated result and NV flag (the output register).
// Optional feature: define FCVTMOD_EN to add the Mod input (fcvtmod.w.d semantics).
module fcvtint_pipe #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NORMSHIFTSZ = 128
) (
  input logic           clk,
  input logic           reset,
  fcvtint_pipe_if.slave bus
);

  // Handshake
  logic w_s2_load, w_s1_load, w_accept;

  // Stage 1 state
  logic            r_s1_valid;
  logic [XLEN:0]   r_s1_m;
  logic            r_s1_signed, r_s1_w64, r_s1_xs, r_s1_nan, r_s1_ovf, r_s1_mod;

  // Stage 2 state
  logic            r_s2_valid;
  logic [XLEN-1:0] r_s2_res;
  logic            r_s2_nv;

  // Stage 1 input decode
  logic            w_mod, w_int64;
  logic [XLEN:0]   w_m;

  // Stage 2 combinational result
  logic [7:0]      w_hbit, w_fbit;
  logic [XLEN:0]   w_half, w_full;
  logic            w_range_ov, w_ov;
  logic [XLEN-1:0] w_val, w_max, w_raw, w_res;
  logic            w_nv;

`ifdef FCVTMOD_EN
  assign w_mod = bus.Mod;
`else
  assign w_mod = 1'b0;
`endif

  // Int64 only matters for a 64-bit datapath; Mod forces a 32-bit result
  assign w_int64 = (XLEN == 64) ? (bus.Int64 & ~w_mod) : 1'b0;
  assign w_m     = {1'b0, bus.Shifted[NORMSHIFTSZ-1 -: XLEN]} + {{XLEN{1'b0}}, bus.Plus1};

  // Low shifter bits carry no integer information here
  if (NORMSHIFTSZ > XLEN) begin : g_low
    logic w_unused_low;
    assign w_unused_low = ^bus.Shifted[NORMSHIFTSZ-XLEN-1:0];
  end

  assign w_s2_load   = ~r_s2_valid | bus.OutReady;
  assign w_s1_load   = ~r_s1_valid | w_s2_load;
  assign bus.InReady = ~reset & w_s1_load;
  assign w_accept    = bus.InValid & bus.InReady;

  // S1: capture rounded magnitude and control bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_m      <= w_m;
        r_s1_signed <= bus.Signed | w_mod;
        r_s1_w64    <= w_int64;
        r_s1_xs     <= bus.Xs;
        r_s1_nan    <= bus.NaN;
        r_s1_ovf    <= bus.ShiftOvf;
        r_s1_mod    <= w_mod;
      end
    end
  end

  // Range limits 2^(W-1) and 2^W for the current width
  always_comb begin
    w_hbit = r_s1_w64 ? 8'(XLEN - 1) : 8'd31;
    w_fbit = r_s1_w64 ? 8'(XLEN) : 8'd32;
    w_half = (XLEN + 1)'(1) << w_hbit;
    w_full = (XLEN + 1)'(1) << w_fbit;
  end

  // Out-of-range detection, saturation and sign application
  always_comb begin
    w_range_ov = 1'b0;
    unique case ({r_s1_signed, r_s1_xs})
      2'b11:   w_range_ov = r_s1_m > w_half;
      2'b10:   w_range_ov = r_s1_m >= w_half;
      2'b01:   w_range_ov = r_s1_m != '0;
      default: w_range_ov = r_s1_m >= w_full;
    endcase
    w_ov  = r_s1_ovf | w_range_ov;
    w_val = r_s1_xs ? (~r_s1_m[XLEN-1:0] + XLEN'(1)) : r_s1_m[XLEN-1:0];
    // Unsigned max is all ones for both widths once the 32-bit sign-extension applies
    w_max = r_s1_signed ? (w_half[XLEN-1:0] - XLEN'(1)) : '1;
    w_raw = w_val;
    w_nv  = 1'b0;
    if (r_s1_mod) begin
      // NaN, or Inf (overflow flagged with a zero magnitude), yields zero
      if (r_s1_nan | (r_s1_ovf & (r_s1_m == '0))) begin
        w_raw = '0;
        w_nv  = 1'b1;
      end else begin
        w_nv  = w_ov;
      end
    end else if (r_s1_nan | (w_ov & ~r_s1_xs)) begin
      w_raw = w_max;
      w_nv  = 1'b1;
    end else if (w_ov) begin
      w_raw = r_s1_signed ? w_half[XLEN-1:0] : '0;
      w_nv  = 1'b1;
    end
    w_res = r_s1_w64 ? w_raw : XLEN'($signed(w_raw[31:0]));
  end

  // S2: output register, holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_nv    <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res <= w_res;
        r_s2_nv  <= w_nv;
      end
    end
  end

  assign bus.OutValid = r_s2_valid;
  assign bus.CvtRes   = r_s2_res;
  assign bus.CvtNV    = r_s2_nv;

endmodule

// File: tb/tb_fcvtint_pipe.sv
// Self-checking bench for fcvtint_pipe (XLEN=64, NORMSHIFTSZ=128): directed
// literal cases, stall/reset behaviour, and randomized traffic against a model.
module tb_fcvtint_pipe;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NSZ  = 128;
`ifdef FCVTMOD_EN
  localparam bit HasMod = 1'b1;
`else
  localparam bit HasMod = 1'b0;
`endif

  logic clk;
  logic reset;
  logic mod_in;
  int   n_checks = 0;
  int   n_errors = 0;

  fcvtint_pipe_if #(.XLEN(XLEN), .NORMSHIFTSZ(NSZ)) bus ();

`ifdef FCVTMOD_EN
  assign bus.Mod = mod_in;
`endif

  fcvtint_pipe #(.XLEN(XLEN), .NORMSHIFTSZ(NSZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        nv;
  } exp_t;
  exp_t exp_q[$];

  // Reference: integer conversion rules in plain wide arithmetic
  function automatic void model(input logic sg, i64, p1, xs, nan, ovf, md,
                                input logic [127:0] sh,
                                output logic [63:0] res, output logic nv);
    logic [127:0] m, half, full, mask, r;
    logic         ov;
    int           w;
    m = {64'd0, sh[127:64]} + {127'd0, p1};
    if (md) begin
      sg  = 1'b1;
      i64 = 1'b0;
    end
    w    = i64 ? 64 : 32;
    half = 128'd1 << (w - 1);
    full = 128'd1 << w;
    mask = full - 128'd1;
    if (sg) ov = ovf | (xs ? (m > half) : (m >= half));
    else    ov = ovf | (xs ? (m != 0) : (m >= full));
    if (md) begin
      if (nan || (ovf && m == 0)) begin r = 0; nv = 1'b1; end
      else begin r = (xs ? (128'd0 - m) : m) & mask; nv = ov; end
    end else if (nan || (ov && !xs)) begin
      r  = sg ? half - 1 : full - 1;
      nv = 1'b1;
    end else if (ov) begin
      r  = sg ? half : 128'd0;
      nv = 1'b1;
    end else begin
      r  = (xs ? (128'd0 - m) : m) & mask;
      nv = 1'b0;
    end
    if (w == 32) res = {{32{r[31]}}, r[31:0]};
    else         res = r[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Scoreboard compare on every cycle the output is valid
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.OutValid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL spurious_out got=%h/%b want=none", bus.CvtRes, bus.CvtNV);
        end else if (bus.CvtRes !== exp_q[0].res || bus.CvtNV !== exp_q[0].nv) begin
          n_errors++;
          $display("FAIL scoreboard got=%h/%b want=%h/%b", bus.CvtRes, bus.CvtNV,
                   exp_q[0].res, exp_q[0].nv);
        end
        if (bus.OutReady && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.InValid && bus.InReady) begin
        model(bus.Signed, bus.Int64, bus.Plus1, bus.Xs, bus.NaN, bus.ShiftOvf,
              HasMod & mod_in, bus.Shifted, e.res, e.nv);
        exp_q.push_back(e);
      end
    end
  end

  task automatic set_in(input logic sg, i64, p1, xs, nan, ovf, md, input logic [63:0] mf);
    bus.Signed   = sg;
    bus.Int64    = i64;
    bus.Plus1    = p1;
    bus.Xs       = xs;
    bus.NaN      = nan;
    bus.ShiftOvf = ovf;
    mod_in       = md;
    bus.Shifted  = {mf, $urandom, $urandom};
    bus.InValid  = 1'b1;
  endtask

  // Present one beat and wait (bounded) for it to be accepted
  task automatic send(input logic sg, i64, p1, xs, nan, ovf, md, input logic [63:0] mf);
    set_in(sg, i64, p1, xs, nan, ovf, md, mf);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.InReady) begin
        @(posedge clk);
        #1 bus.InValid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout got=no_accept want=accept");
    bus.InValid = 1'b0;
  endtask

  // Called right after the accept edge: result appears after the next edge
  task automatic expect_out(input string name, input logic [63:0] r, input logic nv);
    chk({name, "_early"}, {63'd0, bus.OutValid}, 64'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {63'd0, bus.OutValid}, 64'd1);
    chk({name, "_res"}, bus.CvtRes, r);
    chk({name, "_nv"}, {63'd0, bus.CvtNV}, {63'd0, nv});
  endtask

  function automatic logic [63:0] pick_m();
    unique case ($urandom_range(0, 9))
      0:       return 64'($urandom_range(0, 7));
      1:       return 64'h7FFF_FFFE + 64'($urandom_range(0, 3));
      2:       return 64'hFFFF_FFFE + 64'($urandom_range(0, 3));
      3:       return 64'h7FFF_FFFF_FFFF_FFFE + 64'($urandom_range(0, 3));
      4:       return 64'hFFFF_FFFF_FFFF_FFFE + 64'($urandom_range(0, 1));
      5:       return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] mr;
    logic        mnv;
    logic [63:0] mf;
    logic        md;

    reset = 1'b1;
    mod_in = 1'b0;
    bus.OutReady = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 64'd0);
    bus.InValid = 1'b1;

    // Model pinned to hand-computed values
    model(1, 0, 1, 1, 0, 0, 0, {64'd5, 64'd0}, mr, mnv);
    chk("model_neg6", mr, 64'hFFFF_FFFF_FFFF_FFFA);
    model(1, 0, 0, 0, 0, 0, 0, {64'h8000_0000, 64'd0}, mr, mnv);
    chk("model_sat32", mr, 64'h0000_0000_7FFF_FFFF);
    chk("model_sat32_nv", {63'd0, mnv}, 64'd1);
    model(0, 0, 0, 0, 1, 0, 0, {64'd0, 64'd0}, mr, mnv);
    chk("model_nan_u32", mr, 64'hFFFF_FFFF_FFFF_FFFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inready", {63'd0, bus.InReady}, 64'd0);
    chk("rst_outvalid", {63'd0, bus.OutValid}, 64'd0);
    chk("rst_res", bus.CvtRes, 64'd0);
    chk("rst_nv", {63'd0, bus.CvtNV}, 64'd0);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    reset = 1'b0;

    // Directed conversions
    send(1, 0, 1, 1, 0, 0, 0, 64'd5);
    expect_out("t1", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    send(1, 0, 0, 0, 0, 0, 0, 64'h8000_0000);
    expect_out("t2_pos", 64'h0000_0000_7FFF_FFFF, 1'b1);
    send(1, 0, 0, 1, 0, 0, 0, 64'h8000_0000);
    expect_out("t2_neg", 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(0, 1, 0, 1, 0, 0, 0, 64'd0);
    expect_out("t3_negzero", 64'd0, 1'b0);
    send(0, 1, 0, 1, 0, 0, 0, 64'd1);
    expect_out("t3_neg1", 64'd0, 1'b1);
    send(0, 0, 0, 0, 1, 0, 0, 64'd0);
    expect_out("t3_nan", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(1, 1, 0, 1, 0, 0, 0, 64'h8000_0000_0000_0000);
    expect_out("min64", 64'h8000_0000_0000_0000, 1'b0);
    send(0, 1, 1, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_out("u64_round_ovf", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(0, 0, 0, 0, 0, 0, 0, 64'h8000_0000);
    expect_out("wu_sext", 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(1, 0, 0, 1, 0, 1, 0, 64'd3);
    expect_out("s32_shiftovf_neg", 64'hFFFF_FFFF_8000_0000, 1'b1);

    // Back-pressure: two beats fill the pipe, output holds
    repeat (2) @(posedge clk);
    #1 bus.OutReady = 1'b0;
    set_in(1, 0, 1, 1, 0, 0, 0, 64'd5);
    @(negedge clk);
    chk("t4_ready_a", {63'd0, bus.InReady}, 64'd1);
    @(posedge clk);
    #1 set_in(1, 0, 0, 1, 0, 0, 0, 64'h8000_0000);
    @(negedge clk);
    chk("t4_ready_b", {63'd0, bus.InReady}, 64'd1);
    @(posedge clk);
    #1 set_in(0, 1, 0, 1, 0, 0, 0, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_full_ready", {63'd0, bus.InReady}, 64'd0);
      chk("t4_hold_res", bus.CvtRes, 64'hFFFF_FFFF_FFFF_FFFA);
    end
    @(posedge clk);
    #1 bus.OutReady = 1'b1;
    @(negedge clk);
    chk("t4_ready_comb", {63'd0, bus.InReady}, 64'd1);
    @(posedge clk);
    #1 set_in(1, 1, 0, 0, 1, 0, 0, 64'd0);
    chk("t4_b_res", bus.CvtRes, 64'hFFFF_FFFF_8000_0000);
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    chk("t4_c_res", bus.CvtRes, 64'd0);
    chk("t4_c_nv", {63'd0, bus.CvtNV}, 64'd1);
    @(posedge clk);
    #1;
    chk("t4_d_valid", {63'd0, bus.OutValid}, 64'd1);
    chk("t4_d_res", bus.CvtRes, 64'h7FFF_FFFF_FFFF_FFFF);

    // Reset with beats in flight
    repeat (2) @(posedge clk);
    #1 set_in(1, 1, 0, 0, 0, 0, 0, 64'd7);
    @(posedge clk);
    #1 set_in(1, 1, 0, 0, 0, 0, 0, 64'd9);
    @(posedge clk);
    #1 begin
      bus.InValid = 1'b0;
      reset = 1'b1;
    end
    @(negedge clk);
    chk("t5_inready", {63'd0, bus.InReady}, 64'd0);
    @(posedge clk);
    #1;
    chk("t5_flushed", {63'd0, bus.OutValid}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_stale", {63'd0, bus.OutValid}, 64'd0);
    end
    @(posedge clk);
    #1;

`ifdef FCVTMOD_EN
    send(0, 1, 0, 0, 0, 0, 1, 64'h1_0000_0005);
    expect_out("t6_mod_wrap", 64'd5, 1'b1);
    send(0, 1, 0, 0, 1, 0, 1, 64'd0);
    expect_out("t6_mod_nan", 64'd0, 1'b1);
    send(0, 1, 0, 1, 0, 0, 1, 64'd5);
    expect_out("t6_mod_neg", 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    send(0, 1, 0, 0, 0, 1, 1, 64'd0);
    expect_out("t6_mod_inf", 64'd0, 1'b1);
    @(posedge clk);
    #1;
`endif

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      md = HasMod && ($urandom_range(0, 3) == 0);
      mf = pick_m();
      set_in($urandom_range(0, 1), $urandom_range(0, 1),
             md ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 1),
             $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, md, mf);
      if (md && bus.ShiftOvf) bus.Shifted[127:64] = 64'd0;
      bus.InValid  = $urandom_range(0, 3) != 0;
      bus.OutReady = $urandom_range(0, 3) != 0;
      @(posedge clk);
      #1;
    end
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
